// File: rtl/serie_paralelo_rx.sv
// Serial-to-parallel receiver: aligns 10-bit symbols on K28.5 commas and,
// once locked, emits every aligned word with a one-cycle VALID strobe.
module serie_paralelo_rx #(
  parameter int unsigned SYNC_COMMAS = 3,
  parameter logic [9:0]  COMMA_N     = 10'h17C,
  parameter logic [9:0]  COMMA_P     = 10'h283
) (
  input  logic       CLOCK,
  input  logic       RESET_L,
  input  logic       DATA_IN,
  output logic [9:0] D,
  output logic       VALID,
  output logic       IS,
  output logic       COMMA
);

  localparam int unsigned CW = $clog2(SYNC_COMMAS + 1);
  localparam logic [CW-1:0] SC = CW'(SYNC_COMMAS);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] SYNC   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic [9:0]    d_q, d_d;
  logic          valid_q, valid_d;
  logic          is_q, is_d;
  logic          comma_q, comma_d;

  logic [9:0] word;
  logic       is_comma;
  logic       boundary;

  // word includes the bit being sampled on this edge
  assign word     = {DATA_IN, shreg_q[9:1]};
  assign is_comma = (word == COMMA_N) || (word == COMMA_P);
  assign boundary = (bit_cnt_q == 4'd9);

  always_comb begin
    state_d     = state_q;
    shreg_d     = word;
    bit_cnt_d   = boundary ? 4'd0 : bit_cnt_q + 4'd1;
    comma_cnt_d = comma_cnt_q;
    d_d         = d_q;
    valid_d     = 1'b0;
    is_d        = is_q;
    comma_d     = comma_q;
    case (state_q)
      SEARCH: begin
        if (is_comma) begin
          bit_cnt_d   = 4'd0;
          comma_cnt_d = CW'(1);
          if (SYNC_COMMAS == 1) begin
            state_d = SYNC;
            is_d    = 1'b1;
            valid_d = 1'b1;
            d_d     = word;
            comma_d = 1'b1;
          end else begin
            state_d = TRACK;
          end
        end
      end
      TRACK: begin
        if (boundary) begin
          if (is_comma) begin
            if (comma_cnt_q >= SC - CW'(1)) begin
              comma_cnt_d = SC;
              state_d     = SYNC;
              is_d        = 1'b1;
              valid_d     = 1'b1;
              d_d         = word;
              comma_d     = 1'b1;
            end else begin
              comma_cnt_d = comma_cnt_q + CW'(1);
            end
          end else begin
            comma_cnt_d = '0;
            state_d     = SEARCH;
          end
        end else if (is_comma) begin
          // misaligned comma restarts the count at the new phase
          bit_cnt_d   = 4'd0;
          comma_cnt_d = CW'(1);
        end
      end
      SYNC: begin
        if (boundary) begin
          d_d     = word;
          valid_d = 1'b1;
          comma_d = is_comma;
        end else if (is_comma) begin
          is_d        = 1'b0;
          bit_cnt_d   = 4'd0;
          comma_cnt_d = CW'(1);
          state_d     = TRACK;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_L) begin
      state_q     <= SEARCH;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      d_q         <= '0;
      valid_q     <= 1'b0;
      is_q        <= 1'b0;
      comma_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      d_q         <= d_d;
      valid_q     <= valid_d;
      is_q        <= is_d;
      comma_q     <= comma_d;
    end
  end

  assign D     = d_q;
  assign VALID = valid_q;
  assign IS    = is_q;
  assign COMMA = comma_q;

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Bench for serie_paralelo_rx: word table plus hand sequences; every VALID
// is matched against a scoreboard of expected {D, COMMA}.
module tb_serie_paralelo_rx;

  logic       CLOCK = 1'b0;
  logic       RESET_L;
  logic       DATA_IN;
  logic [9:0] D;
  logic       VALID, IS, COMMA;

  serie_paralelo_rx dut (
    .CLOCK  (CLOCK),
    .RESET_L(RESET_L),
    .DATA_IN(DATA_IN),
    .D      (D),
    .VALID  (VALID),
    .IS     (IS),
    .COMMA  (COMMA)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [9:0] d;
    logic       c;
  } exp_t;

  typedef struct {
    logic [9:0] w;
    logic       ev;
    logic       ec;
    logic       eis;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[13];
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  bit   mon_en  = 1'b0;
  bit   spc_en  = 1'b0;
  int   cyc     = 0;
  int   last_v  = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    DATA_IN = b;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic send_word(input logic [9:0] w, input logic ev, input logic ec);
    if (ev) sb.push_back({w, ec});
    for (int i = 0; i < 10; i++) send_bit(w[i]);
  endtask

  always @(posedge CLOCK) cyc <= cyc + 1;

  // scoreboard side: every strobe must match the next expected word
  always @(negedge CLOCK) begin
    if (mon_en && VALID) begin
      if (sb.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_valid: got VALID with D=%0h expected no strobe", D);
      end else begin
        mon_e = sb.pop_front();
        chk("valid_D", {22'd0, D}, {22'd0, mon_e.d});
        chk("valid_COMMA", {31'd0, COMMA}, {31'd0, mon_e.c});
      end
      if (spc_en && last_v >= 0) chk("valid_spacing", cyc - last_v, 10);
      last_v = cyc;
    end
  end

  initial begin
    tbl[0] = '{10'h17C, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{10'h283, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{10'h17C, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 10; k++) tbl[3+k] = '{10'(k + 1), 1'b1, 1'b0, 1'b1};

    // T1: reset held while data toggles
    RESET_L = 1'b0;
    DATA_IN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      DATA_IN = i[0];
      @(posedge CLOCK);
      #1;
      mon_en = 1'b1;
      chk("rst_D", {22'd0, D}, 32'd0);
      chk("rst_VALID", {31'd0, VALID}, 32'd0);
      chk("rst_IS", {31'd0, IS}, 32'd0);
      chk("rst_COMMA", {31'd0, COMMA}, 32'd0);
    end
    RESET_L = 1'b1;

    // T2 + T3: random lead-in, acquisition, then aligned data stream
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
    for (int i = 0; i < 13; i++) begin
      spc_en = (i >= 3);
      send_word(tbl[i].w, tbl[i].ev, tbl[i].ec);
      chk("tbl_IS", {31'd0, IS}, {31'd0, tbl[i].eis});
    end
    spc_en = 1'b0;

    // T4: one slipped bit; the last aligned boundary captures {comma[8:0], 0}
    sb.push_back({10'h2F8, 1'b0});
    send_bit(1'b0);
    chk("slip_IS_still", {31'd0, IS}, 32'd1);
    send_word(10'h17C, 1'b0, 1'b0);
    chk("slip_IS_drop", {31'd0, IS}, 32'd0);
    send_word(10'h283, 1'b0, 1'b0);
    chk("slip_IS_2nd", {31'd0, IS}, 32'd0);
    send_word(10'h17C, 1'b1, 1'b1);
    chk("slip_IS_relock", {31'd0, IS}, 32'd1);

    // T6: single-edge reset at bit 5 of a word while locked
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    RESET_L = 1'b0;
    send_bit(1'b0);
    chk("midrst_D", {22'd0, D}, 32'd0);
    chk("midrst_VALID", {31'd0, VALID}, 32'd0);
    chk("midrst_IS", {31'd0, IS}, 32'd0);
    chk("midrst_COMMA", {31'd0, COMMA}, 32'd0);
    RESET_L = 1'b1;
    send_word(10'h17C, 1'b0, 1'b0);
    chk("midrst_IS_1", {31'd0, IS}, 32'd0);
    send_word(10'h283, 1'b0, 1'b0);
    chk("midrst_IS_2", {31'd0, IS}, 32'd0);
    send_word(10'h17C, 1'b1, 1'b1);
    chk("midrst_IS_3", {31'd0, IS}, 32'd1);

    // T5: comma followed by data must fall back to SEARCH, not keep the count
    RESET_L = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    RESET_L = 1'b1;
    send_word(10'h17C, 1'b0, 1'b0);
    send_word(10'h155, 1'b0, 1'b0);
    chk("false_IS", {31'd0, IS}, 32'd0);
    send_word(10'h283, 1'b0, 1'b0);
    send_word(10'h17C, 1'b0, 1'b0);
    chk("false_IS_two", {31'd0, IS}, 32'd0);
    send_word(10'h283, 1'b1, 1'b1);
    chk("false_IS_lock", {31'd0, IS}, 32'd1);

    repeat (3) send_bit(1'b0);
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
